// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment vectors are {g,f,e,d,c,b,a}, where bit 0 is a and 0 means lit.
package sseg_pkg;

  typedef logic [4:0] glyph_t;

  localparam glyph_t G_H    = 5'd10;
  localparam glyph_t G_N    = 5'd11;
  localparam glyph_t G_G    = 5'd12;
  localparam glyph_t G_S    = 5'd13;
  localparam glyph_t G_L    = 5'd14;
  localparam glyph_t G_P    = 5'd15;
  localparam glyph_t G_B    = 5'd16;
  localparam glyph_t G_T    = 5'd17;
  localparam glyph_t G_F    = 5'd18;
  localparam glyph_t G_U    = 5'd19;
  localparam glyph_t G_E    = 5'd20;
  localparam glyph_t G_X    = 5'd21;
  localparam glyph_t G_DASH = 5'd31;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_N     = 7'b1001000;
  localparam logic [6:0] SEG_G     = 7'b1000010;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_T     = 7'b0000111;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_X     = 7'b0001001;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/sseg_glyph_rom.sv
// Combinational glyph lookup: 5-bit code to active-low segment pattern.
module sseg_glyph_rom
  import sseg_pkg::*;
(
  input  glyph_t     code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (code)
      5'd0:    seg = SEG_0;
      5'd1:    seg = SEG_1;
      5'd2:    seg = SEG_2;
      5'd3:    seg = SEG_3;
      5'd4:    seg = SEG_4;
      5'd5:    seg = SEG_5;
      5'd6:    seg = SEG_6;
      5'd7:    seg = SEG_7;
      5'd8:    seg = SEG_8;
      5'd9:    seg = SEG_9;
      G_H:     seg = SEG_H;
      G_N:     seg = SEG_N;
      G_G:     seg = SEG_G;
      G_S:     seg = SEG_S;
      G_L:     seg = SEG_L;
      G_P:     seg = SEG_P;
      G_B:     seg = SEG_B;
      G_T:     seg = SEG_T;
      G_F:     seg = SEG_F;
      G_U:     seg = SEG_U;
      G_E:     seg = SEG_E;
      G_X:     seg = SEG_X;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// Multiplexed seven-segment scanner with guard gaps, per-digit enable/blink,
// and atomically loaded shadow registers.
//   state    | meaning
//   ST_GUARD | all anodes off for GUARD cycles before each slot
//   ST_SHOW  | digit idx driven for SCAN_DIV cycles (blanked if disabled/blinking)
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int GUARD     = 16,
  parameter int BLINK_DIV = 12500000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5*N_DIGITS-1:0] codes_i,
  input  logic [N_DIGITS-1:0]   en_mask_i,
  input  logic [N_DIGITS-1:0]   blink_mask_i,
  input  logic                  load_i,
  output logic [6:0]            sseg_o,
  output logic [N_DIGITS-1:0]   an_o
);

  localparam int CNT_MAX = (GUARD > SCAN_DIV) ? GUARD : SCAN_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int BLK_W   = $clog2(BLINK_DIV);
  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  scan_state_t          state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [BLK_W-1:0]     blink_cnt;
  logic                 blink_phase;
  glyph_t               codes_q [N_DIGITS];
  logic [N_DIGITS-1:0]  en_q, blink_q;
  glyph_t               code_sel;
  logic [6:0]           glyph_seg;
  logic [6:0]           seg_nxt;
  logic [N_DIGITS-1:0]  an_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_DIGITS; k++) codes_q[k] <= G_DASH;
      en_q    <= '1;
      blink_q <= '0;
    end else if (load_i) begin
      for (int k = 0; k < N_DIGITS; k++) codes_q[k] <= codes_i[5*k +: 5];
      en_q    <= en_mask_i;
      blink_q <= blink_mask_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_GUARD;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    case (state)
      ST_GUARD: begin
        if (cnt == CNT_W'(GUARD - 1)) begin
          state_nxt = ST_SHOW;
          cnt_nxt   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt == CNT_W'(SCAN_DIV - 1)) begin
          state_nxt = ST_GUARD;
          cnt_nxt   = '0;
          idx_nxt   = (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_GUARD;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign code_sel = codes_q[idx];

  sseg_glyph_rom u_rom (
    .code (code_sel),
    .seg  (glyph_seg)
  );

  // Blanked digits keep their slot; only the anode and segments stay dark.
  always_comb begin
    an_nxt  = '1;
    seg_nxt = SEG_BLANK;
    if (state == ST_SHOW && en_q[idx] && !(blink_q[idx] && blink_phase)) begin
      an_nxt[idx] = 1'b0;
      seg_nxt     = glyph_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_o   <= '1;
      sseg_o <= SEG_BLANK;
    end else begin
      an_o   <= an_nxt;
      sseg_o <= seg_nxt;
    end
  end

endmodule

// File: doc/sseg_scan_driver.md
SSEG_SCAN_DRIVER -- requirements
Module: sseg_scan_driver

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed digits, range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000: clock cycles each digit is lit per slot, at least 2.
REQ-003 Parameter GUARD, default 16: all-anodes-off cycles before each slot (anti-ghosting), at least 1.
REQ-004 Parameter BLINK_DIV, default 12500000: clock cycles per blink half-period, at least 2.
REQ-005 clk  in  1  single system clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 codes_i  in  5*N_DIGITS  glyph code per digit; digit k occupies bits [5k+4:5k].
REQ-008 en_mask_i  in  N_DIGITS  1 = digit k enabled.
REQ-009 blink_mask_i  in  N_DIGITS  1 = digit k blinks.
REQ-010 load_i  in  1  one-cycle strobe that captures codes_i, en_mask_i and blink_mask_i.
REQ-011 sseg_o  out  7  active-low segments, ordered a..g with bit 0 = a.
REQ-012 an_o  out  N_DIGITS  active-low anode enables; bit k drives digit k.

Function
REQ-013 Glyph codes shall map as follows; every other code shall show "-" (only g lit):
  - 0..9: digits "0".."9".
  - 10..21: letters H, N, G, S, L, P, B, T, F, U, E, X, in that order.
REQ-014 Segment patterns: "0"=0000001, "8"=0000000, "H"=1001000, "-"=1111110 (a..g, 0 = lit); all other digit and letter patterns shall follow the standard seven-segment glyph shapes.
REQ-015 Shadow registers (codes, en mask, blink mask) shall update only on a clock edge where load_i=1; all three shall be captured in the same edge, so no tearing.
REQ-016 Scan FSM shall have two states:
  - GUARD: lasts GUARD cycles; all anodes off.
  - SHOW: lasts SCAN_DIV cycles; selected digit lit.
REQ-017 Transitions: GUARD->SHOW after GUARD cycles; SHOW->GUARD after SCAN_DIV cycles; the digit index shall advance on SHOW exit, wrapping N_DIGITS-1 -> 0.
REQ-018 In SHOW, an_o shall be low only on bit idx, and only if en[idx]=1 and not (blink[idx]=1 and blink_phase=1).
REQ-019 A disabled or blanked digit shall still consume its full slot, so brightness of the other digits is unchanged.
REQ-020 sseg_o shall be all ones whenever an_o is all ones; otherwise it shall be the glyph of shadow code[idx].
REQ-021 Outputs shall be registered, one-cycle latency after the state/index/shadow values they reflect.
REQ-022 A load in cycle t shall be visible on the outputs from cycle t+2, including when it lands mid-SHOW.
REQ-023 blink_phase shall toggle every BLINK_DIV cycles, free-running and independent of load and scan.
REQ-024 load_i held high shall recapture on every edge (last value wins); there is no busy or ready handshake.
REQ-025 Counter widths shall be derived by clog2 of the respective parameter; no counter shall overflow.

Reset
REQ-026 While rst_n=0, outputs shall read all ones immediately: an_o all ones, sseg_o = 1111111.
REQ-027 Reset values: FSM=GUARD, idx=0, all counters 0, blink_phase=0, shadow codes=31 (dash), en mask all ones, blink mask all zeros.
REQ-028 The first lit output after reset release shall be digit 0 showing "-", GUARD+1 cycles after the first clk edge.
REQ-029 Reset asserted mid-slot shall abort the slot with no partial-state carry-over.

Structure
REQ-030 Shared package sseg_pkg shall hold:
  - the 5-bit glyph code type;
  - named code constants (G_H=10 .. G_X=21, G_DASH=31);
  - the 7-bit segment pattern constants;
  - the FSM state enum.
REQ-031 One sub-module, sseg_glyph_rom: purely combinational 5-bit code -> 7-bit pattern, instantiated once on the muxed code.

Verification
REQ-032 All directed scenarios shall use N_DIGITS=4, SCAN_DIV=4, GUARD=1, BLINK_DIV=16.
REQ-033 Reset release with no load -> an_o cycles 1110, 1101, 1011, 0111, each low for 4 cycles separated by 1 all-high cycle; sseg_o=1111110 while lit.
REQ-034 Load codes {3,2,1,0} (digit 3..0), en=1111 -> digit 0 shows 0000001, digit 1 shows 1001111, digit 2 shows 0010010, digit 3 shows 0000110.
REQ-035 Load codes {21,10,22,31} -> digit 3 shows "X", digit 2 shows "H", digits 1 and 0 show "-".
REQ-036 en=1010, blink=0010 -> digits 0 and 2 are never lit and their slots stay timed; digit 1 is lit only while blink_phase=0, toggling every 16 cycles; digit 3 is always lit.
REQ-037 Load asserted during the third SHOW cycle of digit 1 -> the new glyph appears 2 cycles later in the same slot.
REQ-038 rst_n pulsed low mid-SHOW -> outputs go all ones in the same cycle; the restart follows REQ-033 and the shadow codes revert to dash.
